// File: rtl/issue_queue.sv
// 32-entry out-of-order issue queue: dispatch into the lowest free slot, wakeup by tag
// broadcast, select-tree grant, registered issue port. Optional macro: IQ_ISSUE_WAKEUP_EN.
module issue_queue #(
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned DEPTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [PREG_W-1:0]    disp_src0,
    input  logic                 disp_src0_rdy,
    input  logic [PREG_W-1:0]    disp_src1,
    input  logic                 disp_src1_rdy,
    input  logic [PREG_W-1:0]    disp_dst,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic                 wb_valid,
    input  logic [PREG_W-1:0]    wb_preg,
    output logic [DEPTH-1:0]     req_vec,
    input  logic                 sel_valid,
    input  logic [4:0]           sel_addr,
    output logic                 iss_valid,
    output logic [PREG_W-1:0]    iss_dst,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic [5:0]           count
);

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     src0_rdy_q;
    logic [DEPTH-1:0]     src1_rdy_q;
    logic [PREG_W-1:0]    src0_q    [DEPTH];
    logic [PREG_W-1:0]    src1_q    [DEPTH];
    logic [PREG_W-1:0]    dst_q     [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [5:0]           count_q, count_d;
    logic                 iss_valid_q;
    logic [PREG_W-1:0]    iss_dst_q;
    logic [PAYLOAD_W-1:0] iss_payload_q;

    logic                 disp_fire, issue_fire;
    logic [4:0]           free_idx;
    logic                 iw_valid;
    logic [PREG_W-1:0]    iw_preg;

    assign req_vec     = valid_q & src0_rdy_q & src1_rdy_q;
    assign disp_ready  = (count_q != 6'd32);
    assign disp_fire   = disp_valid && disp_ready && !flush;
    assign issue_fire  = sel_valid && req_vec[sel_addr] && !flush;
    assign count       = count_q;
    assign iss_valid   = iss_valid_q;
    assign iss_dst     = iss_dst_q;
    assign iss_payload = iss_payload_q;

`ifdef IQ_ISSUE_WAKEUP_EN
    // Issued dst doubles as a wakeup tag so a dependent op can request next cycle.
    assign iw_valid = issue_fire;
    assign iw_preg  = dst_q[sel_addr];
`else
    assign iw_valid = 1'b0;
    assign iw_preg  = '0;
`endif

    function automatic logic tag_hit(input logic [PREG_W-1:0] tag);
        return (wb_valid && (wb_preg == tag)) || (iw_valid && (iw_preg == tag));
    endfunction

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = 5'(i);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({disp_fire, issue_fire})
            2'b10:   count_d = count_q + 6'd1;
            2'b01:   count_d = count_q - 6'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            count_q       <= '0;
            iss_valid_q   <= 1'b0;
            iss_dst_q     <= '0;
            iss_payload_q <= '0;
        end else if (flush) begin
            valid_q     <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            iss_valid_q <= issue_fire;
            if (issue_fire) begin
                valid_q[sel_addr] <= 1'b0;
                iss_dst_q         <= dst_q[sel_addr];
                iss_payload_q     <= payload_q[sel_addr];
            end
            // The free slot is never the issued one, so both updates can coexist.
            if (disp_fire) valid_q[free_idx] <= 1'b1;
            count_q <= count_d;
        end
    end

    // Entry payload/tags carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && tag_hit(src0_q[i])) src0_rdy_q[i] <= 1'b1;
            if (valid_q[i] && tag_hit(src1_q[i])) src1_rdy_q[i] <= 1'b1;
        end
        if (disp_fire) begin
            src0_q[free_idx]     <= disp_src0;
            src1_q[free_idx]     <= disp_src1;
            src0_rdy_q[free_idx] <= disp_src0_rdy || tag_hit(disp_src0);
            src1_rdy_q[free_idx] <= disp_src1_rdy || tag_hit(disp_src1);
            dst_q[free_idx]      <= disp_dst;
            payload_q[free_idx]  <= disp_payload;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: stimulus pushes expected issues, a negedge monitor checks them.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_src0, disp_src1, disp_dst;
    logic        disp_src0_rdy, disp_src1_rdy;
    logic [63:0] disp_payload;
    logic        wb_valid;
    logic [5:0]  wb_preg;
    logic [31:0] req_vec;
    logic        sel_valid;
    logic [4:0]  sel_addr;
    logic        iss_valid;
    logic [5:0]  iss_dst;
    logic [63:0] iss_payload;
    logic [5:0]  count;

    typedef struct packed {
        logic [5:0]  dst;
        logic [63:0] payload;
    } iss_t;

    iss_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef IQ_ISSUE_WAKEUP_EN
    localparam logic [31:0] ReqAfterIw = 32'h0000_005B;
`else
    localparam logic [31:0] ReqAfterIw = 32'h0000_001B;
`endif

    issue_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_src0    (disp_src0),
        .disp_src0_rdy(disp_src0_rdy),
        .disp_src1    (disp_src1),
        .disp_src1_rdy(disp_src1_rdy),
        .disp_dst     (disp_dst),
        .disp_payload (disp_payload),
        .wb_valid     (wb_valid),
        .wb_preg      (wb_preg),
        .req_vec      (req_vec),
        .sel_valid    (sel_valid),
        .sel_addr     (sel_addr),
        .iss_valid    (iss_valid),
        .iss_dst      (iss_dst),
        .iss_payload  (iss_payload),
        .count        (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; disp_src0 = '0; disp_src0_rdy = 1'b0;
        disp_src1 = '0; disp_src1_rdy = 1'b0; disp_dst = '0; disp_payload = '0;
        wb_valid = 1'b0; wb_preg = '0; sel_valid = 1'b0; sel_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_disp(input logic [5:0] s0, input logic r0, input logic [5:0] s1,
                            input logic r1, input logic [5:0] d, input logic [63:0] p);
        disp_valid = 1'b1; disp_src0 = s0; disp_src0_rdy = r0;
        disp_src1 = s1; disp_src1_rdy = r1; disp_dst = d; disp_payload = p;
    endtask

    task automatic grant(input logic [4:0] a);
        sel_valid = 1'b1; sel_addr = a;
    endtask

    task automatic expect_iss(input logic [5:0] d, input logic [63:0] p);
        iss_t e;
        e.dst = d; e.payload = p;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented issue must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && iss_valid) begin
            iss_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue actual=dst %0h required=no issue", iss_dst);
            end else begin
                e = exp_q.pop_front();
                if (iss_dst !== e.dst || iss_payload !== e.payload) begin
                    failures++;
                    $display("FAIL issue_data actual=%0h/%0h required=%0h/%0h",
                             iss_dst, iss_payload, e.dst, e.payload);
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_req_vec", 64'(req_vec), 64'd0);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_iss_dst", 64'(iss_dst), 64'd0);
        check("rst_iss_payload", iss_payload, 64'd0);

        // Fill all 32 entries; entry i gets dst i^0x2D (entry 7 -> 0x2A).
        for (int i = 0; i < 32; i++) begin
            set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'(i) ^ 6'h2D, 64'h1000 + 64'(i));
            tick();
        end
        check("full_count", 64'(count), 64'd32);
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        check("full_req_vec", 64'(req_vec), 64'hFFFF_FFFF);
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h3F, 64'hDEAD);
        tick();
        check("drop33_count", 64'(count), 64'd32);

        // Full: issue entry 0 with a concurrent dispatch, which must be dropped.
        grant(5'd0);
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h3F, 64'hBEEF);
        expect_iss(6'h2D, 64'h1000);
        tick();
        check("full_iss_count", 64'(count), 64'd31);
        check("full_iss_req_vec", 64'(req_vec), 64'hFFFF_FFFE);
        check("full_iss_valid", 64'(iss_valid), 64'd1);
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h3E, 64'hAAAA);
        tick();
        check("refill_count", 64'(count), 64'd32);
        check("refill_req_vec", 64'(req_vec), 64'hFFFF_FFFF);

        // Issue entry 0 again: proves the refill landed there.
        grant(5'd0);
        expect_iss(6'h3E, 64'hAAAA);
        tick();
        check("refill_iss_count", 64'(count), 64'd31);
        grant(5'd7);
        expect_iss(6'h2A, 64'h1007);
        tick();
        check("iss7_valid", 64'(iss_valid), 64'd1);
        check("iss7_dst", 64'(iss_dst), 64'h2A);
        check("iss7_req_vec", 64'(req_vec), 64'hFFFF_FF7E);
        check("iss7_count", 64'(count), 64'd30);
        grant(5'd7);
        tick();
        check("nonreq_iss_valid", 64'(iss_valid), 64'd0);
        check("nonreq_count", 64'(count), 64'd30);

        flush = 1'b1;
        tick();
        check("flush1_count", 64'(count), 64'd0);

        // Wakeup: entry 3 waits on src0=0x12.
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h01, 64'h2000);
        tick();
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h02, 64'h2001);
        tick();
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h30, 64'h2002);
        tick();
        set_disp(6'h12, 1'b0, 6'h00, 1'b1, 6'h03, 64'h2003);
        tick();
        check("wait_req_vec", 64'(req_vec), 64'h7);
        wb_valid = 1'b1; wb_preg = 6'h12;
        #1;
        check("no_bypass_req_vec", 64'(req_vec), 64'h7);
        tick();
        check("woken_req_vec", 64'(req_vec), 64'hF);

        // Same-cycle capture into entry 4; entry 5 has a non-matching tag.
        set_disp(6'h00, 1'b1, 6'h05, 1'b0, 6'h04, 64'h2004);
        wb_valid = 1'b1; wb_preg = 6'h05;
        tick();
        check("capture_req_vec", 64'(req_vec), 64'h1F);
        set_disp(6'h00, 1'b1, 6'h06, 1'b0, 6'h05, 64'h2005);
        wb_valid = 1'b1; wb_preg = 6'h05;
        tick();
        check("nocapture_req_vec", 64'(req_vec), 64'h1F);

        // Entry 6 depends on entry 2's dst 0x30.
        set_disp(6'h30, 1'b0, 6'h00, 1'b1, 6'h06, 64'h2006);
        tick();
        check("dep_count", 64'(count), 64'd7);
        grant(5'd2);
        expect_iss(6'h30, 64'h2002);
        tick();
        check("iss_wakeup_req_vec", 64'(req_vec), 64'(ReqAfterIw));
        check("iss_wakeup_count", 64'(count), 64'd6);
        wb_valid = 1'b1; wb_preg = 6'h30;
        tick();
        check("dep_woken_req_vec", 64'(req_vec), 64'h5B);

        // Bring to 10 entries (slots 2,7,8,9), then flush with dispatch and grant.
        for (int i = 0; i < 4; i++) begin
            set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h10 + 6'(i), 64'h3000 + 64'(i));
            tick();
        end
        check("ten_count", 64'(count), 64'd10);
        check("ten_req_vec", 64'(req_vec), 64'h3DF);
        flush = 1'b1;
        grant(5'd0);
        set_disp(6'h00, 1'b1, 6'h00, 1'b1, 6'h3F, 64'h4000);
        tick();
        check("flush_count", 64'(count), 64'd0);
        check("flush_req_vec", 64'(req_vec), 64'd0);
        check("flush_iss_valid", 64'(iss_valid), 64'd0);
        check("flush_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- 32-entry out-of-order issue queue that sits directly upstream of the select tree.
- Holds dispatched micro-ops and tracks operand readiness via writeback wakeup broadcast.
- Presents a per-entry request vector to the select tree, which returns the chosen 5-bit entry address.
- The queue then reads out that entry, frees it and drives the issue port one cycle later.

Parameters:
- PREG_W, 6, physical register tag width.
- PAYLOAD_W, 64, opaque micro-op payload width (opcode, imm, etc.).
- DEPTH, 32, entry count; fixed to 32 so the entry address is 5 bits; other values unsupported.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline flush; invalidates all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch this cycle (= not full).
- disp_src0  in  PREG_W  source 0 tag.
- disp_src0_rdy  in  1  source 0 already available.
- disp_src1  in  PREG_W  source 1 tag.
- disp_src1_rdy  in  1  source 1 already available.
- disp_dst  in  PREG_W  destination tag.
- disp_payload  in  PAYLOAD_W  micro-op payload.
- wb_valid  in  1  writeback wakeup broadcast valid.
- wb_preg  in  PREG_W  tag being written back.
- req_vec  out  32  bit i = entry i valid and both sources ready; feeds the select tree.
- sel_valid  in  1  select-tree grant valid (tree's OR-of-ready output).
- sel_addr  in  5  granted entry address from the select tree.
- iss_valid  out  1  issued micro-op valid.
- iss_dst  out  PREG_W  issued destination tag.
- iss_payload  out  PAYLOAD_W  issued payload.
- count  out  6  number of valid entries, 0..32.

Behaviour:
- Reset (rst=1 at posedge):
  - all entry valid bits = 0.
  - count=0, iss_valid=0, iss_dst=0, iss_payload=0.
  - disp_ready=1 after reset; req_vec=0.
- Entry state: valid, src0, src0_rdy, src1, src1_rdy, dst, payload.
- Dispatch:
  - Accepted when disp_valid and disp_ready.
  - Writes the lowest-index free entry at the clock edge.
  - disp_ready = (count != 32), computed from registered state only.
  - A dispatch in the same cycle as an issue is accepted only if not full before that cycle.
- Wakeup:
  - When wb_valid, every valid entry whose src tag equals wb_preg sets that src_rdy at the edge.
  - A same-cycle dispatch whose disp_srcN == wb_preg is written with src_rdy=1, so the wakeup is never missed.
- Request vector: req_vec is combinational from registered entry state; no same-cycle wakeup bypass into req_vec.
- Issue:
  - Issue fires when sel_valid and req_vec[sel_addr]=1.
  - At that edge: entry sel_addr is cleared, and iss_valid/iss_dst/iss_payload are registered from it.
  - Latency is one cycle from grant to iss_valid.
  - If sel_valid=0, or the granted entry is not requesting: iss_valid=0 next cycle, no state change.
- count: next = count + accepted dispatch − fired issue. Simultaneous dispatch and issue leaves count unchanged.
- Flush:
  - Highest priority.
  - Clears all valid bits and count; iss_valid=0 next cycle.
  - Any dispatch or issue in the flush cycle is dropped.
- One dispatch and one issue per cycle maximum. A dispatch may reuse a slot only after it has been freed, never in the same cycle.

Optional Feature:
- Macro: IQ_ISSUE_WAKEUP_EN.
- Defined:
  - The dst of the entry issued this cycle is broadcast as a second wakeup tag at the issue edge, applying the same rules as wb_preg, including the dispatch-capture rule.
  - This enables back-to-back dependent issue: dependent request appears the cycle after its producer's grant.
- Undefined: only wb_preg wakes entries.

Test Plan:
- Reset, then dispatch 32 ops with both sources ready -> count=32, disp_ready=0, req_vec=0xFFFFFFFF; 33rd dispatch is dropped.
- Dispatch an op into entry 3 with src0=0x12 not ready; then wb_valid with wb_preg=0x12 -> req_vec[3]=0 before the wakeup edge and 1 after it.
- Dispatch with disp_src1=0x05 in the same cycle as wb_preg=0x05 -> entry stored ready; req_vec bit=1 next cycle.
- Grant sel_valid=1, sel_addr=7 on a ready entry with dst=0x2A -> next cycle iss_valid=1, iss_dst=0x2A, req_vec[7]=0, count decremented; a grant on a non-requesting entry gives iss_valid=0.
- At count=32, issue entry 0 and dispatch in the same cycle -> dispatch dropped, count=31; next-cycle dispatch lands in entry 0.
- Flush with 10 valid entries plus a concurrent dispatch and grant -> count=0, req_vec=0, iss_valid=0; with IQ_ISSUE_WAKEUP_EN, issuing dst=0x30 sets a dependent entry's req_vec bit the cycle after the grant.
